// File: rtl/dmem_responder_pkg.sv
// Shared types and helpers for the data-memory responder and its storage array.
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    RAM_BYTE    = 2'b00,
    RAM_HALF    = 2'b01,
    RAM_WORD    = 2'b10,
    RAM_ILLEGAL = 2'b11
  } ram_size_e;

  typedef logic [1:0] dmem_state_e;
  localparam dmem_state_e ST_IDLE = 2'd0;
  localparam dmem_state_e ST_WAIT = 2'd1;
  localparam dmem_state_e ST_RESP = 2'd2;

  // Request fields captured on acceptance; addr is already wrapped/aligned when faults are off
  typedef struct packed {
    logic [31:0] addr;
    ram_size_e   size;
    logic        uns;
    logic        wr;
    logic        fault;
  } dmem_req_t;

  function automatic logic [31:0] align_addr(input logic [31:0] addr, input ram_size_e size);
    case (size)
      RAM_BYTE: return addr;
      RAM_HALF: return {addr[31:1], 1'b0};
      default:  return {addr[31:2], 2'b00};
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input ram_size_e size, input logic [1:0] off);
    case (size)
      RAM_BYTE: return 4'b0001 << off;
      RAM_HALF: return 4'b0011 << off;
      default:  return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] raw, input ram_size_e size,
                                              input logic uns, input logic [1:0] off);
    logic [31:0] s;
    s = raw >> {off, 3'b000};
    case (size)
      RAM_BYTE: return uns ? {24'h0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
      RAM_HALF: return uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default:  return s;
    endcase
  endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Byte-array storage: byte-enabled word write port, combinational word read port.
module dmem_array #(
  parameter int unsigned MEM_SIZE = 1024,
  parameter int unsigned AW       = $clog2(MEM_SIZE)
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [3:0]    be,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [7:0]    mem [MEM_SIZE];
  logic [AW-1:0] wbase;
  logic [AW-1:0] rbase;

  assign wbase = waddr & ~AW'(3);
  assign rbase = raddr & ~AW'(3);

  // Contents are deliberately not reset
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) mem[wbase + AW'(i)] <= wdata[8*i +: 8];
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 4; i++) rdata[8*i +: 8] = mem[rbase + AW'(i)];
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with wait states and held response.
// DMEM_ERR_CHECK_EN enables fault detection; otherwise addresses wrap and are force-aligned.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned MEM_SIZE    = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_wr_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int unsigned AW      = $clog2(MEM_SIZE);
  localparam logic [4:0]  WS      = 5'(WAIT_STATES);
  localparam bit          NO_WAIT = (WAIT_STATES == 0);

  dmem_state_e state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  dmem_req_t   in_req, req_q, cur;
  logic        accept, load_rsp;
  logic [31:0] raw_word, rdata_nxt;
  logic        unused_bits;

  // Decode the incoming request into its effective address, size and fault flag
  always_comb begin
    in_req       = '0;
    in_req.wr    = req_wr_i;
    in_req.uns   = req_unsigned_i;
`ifdef DMEM_ERR_CHECK_EN
    in_req.size  = ram_size_e'(req_size_i);
    in_req.addr  = req_addr_i;
    in_req.fault = (req_size_i == 2'b11)
                || (req_size_i == 2'b01 && req_addr_i[0])
                || (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00)
                || (req_addr_i >= 32'(MEM_SIZE));
`else
    in_req.size  = (req_size_i == 2'b11) ? RAM_WORD : ram_size_e'(req_size_i);
    in_req.addr  = align_addr(32'(req_addr_i[AW-1:0]), in_req.size);
`endif
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    accept    = 1'b0;
    load_rsp  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req_valid_i) begin
          accept = 1'b1;
          if (NO_WAIT) begin
            state_nxt = ST_RESP;
            load_rsp  = 1'b1;
          end else begin
            state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (({1'b0, cnt} + 5'd1) == WS) begin
          state_nxt = ST_RESP;
          load_rsp  = 1'b1;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      ST_RESP: if (rsp_ready_i) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // With zero wait states the response is built from the request being accepted
  assign cur       = (state == ST_IDLE) ? in_req : req_q;
  assign rdata_nxt = (cur.wr || cur.fault) ? 32'h0
                   : extend_load(raw_word, cur.size, cur.uns, cur.addr[1:0]);

  dmem_array #(.MEM_SIZE(MEM_SIZE), .AW(AW)) u_array (
    .clock (clock),
    .we    (accept && req_wr_i && !in_req.fault),
    .waddr (in_req.addr[AW-1:0]),
    .be    (byte_en(in_req.size, in_req.addr[1:0])),
    .wdata (req_wdata_i << {in_req.addr[1:0], 3'b000}),
    .raddr (cur.addr[AW-1:0]),
    .rdata (raw_word)
  );

`ifdef DMEM_ERR_CHECK_EN
  logic err_q;
  assign rsp_err_o = err_q;
`else
  assign rsp_err_o = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      req_q       <= '0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
`ifdef DMEM_ERR_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      req_ready_o <= (state_nxt == ST_IDLE);
      rsp_valid_o <= (state_nxt == ST_RESP);
      if (accept)   req_q       <= in_req;
      if (load_rsp) rsp_rdata_o <= rdata_nxt;
`ifdef DMEM_ERR_CHECK_EN
      if (load_rsp) err_q       <= cur.fault;
`endif
    end
  end

  assign unused_bits = ^{req_addr_i, req_q.addr};

endmodule
